// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive buffer: IO map positions and status word layout.
package uart_rx_fifo_pkg;

    localparam int DEPTH_DEFAULT  = 16;
    localparam int ADDR_W_DEFAULT = 4;

    localparam int IO_UART_RX_DATA_BIT = 2;
    localparam int IO_UART_CTRL        = 3;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 2;
    localparam int ST_OVR    = 3;
    localparam int ST_HALF   = 4;

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// DEPTH x 8 simple dual-port storage with synchronous write and registered, enabled read.
module uart_rx_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a pop from the slot being overwritten returns the old byte.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the CPU IO read mux; keeps bytes while the CPU is busy.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rx_dv,
    input  logic [7:0]      rx_byte,
    input  logic            pop,
    input  logic            clr,
    output logic [7:0]      rd_data,
    output logic [7:0]      status,
    output logic [ADDR_W:0] count
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overrun;
    logic              rd_zero;
    logic [7:0]        ram_q;
    logic              empty;
    logic              full;
    logic              half;
    logic              pop_eff;
    logic              push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (ADDR_W+1)'(DEPTH));
    assign half    = (count_q >= (ADDR_W+1)'(DEPTH/2));
    assign pop_eff = pop & ~empty & ~clr;
    assign push    = rx_dv & (~full | pop_eff) & ~clr;

    uart_rx_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (rx_byte),
        .re    (pop_eff),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // rd_zero masks the RAM read register after reset or a pop on empty,
    // so the storage itself never needs a reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            overrun <= 1'b0;
            rd_zero <= 1'b1;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_eff})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rx_dv && full && !pop_eff) begin
                overrun <= 1'b1;
            end
            if (pop) begin
                rd_zero <= empty;
            end
        end
    end

    assign rd_data = rd_zero ? 8'h00 : ram_q;
    assign count   = count_q;

    always_comb begin
        status            = 8'h00;
        status[ST_NEMPTY] = ~empty;
        status[ST_FULL]   = full;
        status[ST_OVR]    = overrun;
        status[ST_HALF]   = half;
    end

endmodule
